// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//
// Write-back stage of the five-stage pipeline. Registers the MEM-stage result,
// selects ALU result or load data, and drives the decode-stage register-file
// write port (also used as the forwarding source by the hazard logic). Once a
// HALT retires, all architectural writes are frozen until reset.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   When defined, a saturating 32-bit retired-instruction counter is exposed
//   on retire_cnt. When undefined, the port and counter do not exist.
//
// Ports:
//   clk               in   single clock, rising-edge
//   reset             in   synchronous, active-high
//   valid_f_mem       in   MEM stage holds a real instruction (0 = bubble)
//   opcode_f_mem      in   6-bit opcode
//   alu_result_f_mem  in   EX/ALU result
//   mem_data_f_mem    in   load data
//   rd_add_f_mem      in   destination register
//   mem_to_reg_f_mem  in   instruction writes a register
//   mem_read_f_mem    in   instruction is a load (selects mem data)
//   w_2_id            out  register-file write enable
//   addr_2_id         out  register-file write address
//   write_data_2_id   out  register-file write data
//   halted            out  HALT has retired
//   retire_cnt        out  retired-instruction count (WB_RETIRE_CNT_EN only)
//
// States:
//   ST_RUN    | normal operation, writes allowed
//   ST_HALTED | HALT retired; writes blocked until reset
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int D_SIZE        = 32,
    parameter int ADDR_LINE_REG = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_f_mem,
    input  logic [5:0]               opcode_f_mem,
    input  logic [D_SIZE-1:0]        alu_result_f_mem,
    input  logic [D_SIZE-1:0]        mem_data_f_mem,
    input  logic [ADDR_LINE_REG-1:0] rd_add_f_mem,
    input  logic                     mem_to_reg_f_mem,
    input  logic                     mem_read_f_mem,
    output logic                     w_2_id,
    output logic [ADDR_LINE_REG-1:0] addr_2_id,
    output logic [D_SIZE-1:0]        write_data_2_id,
    output logic                     halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]              retire_cnt
`endif
);

    localparam logic [5:0] OP_HALT = 6'b010001;
    localparam logic [5:0] OP_NOP  = 6'b111111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Stage register
    logic                     valid_q;
    logic [5:0]               opcode_q;
    logic [D_SIZE-1:0]        alu_q;
    logic [D_SIZE-1:0]        mem_q;
    logic [ADDR_LINE_REG-1:0] rd_q;
    logic                     m2r_q;
    logic                     mrd_q;

    logic is_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            alu_q    <= '0;
            mem_q    <= '0;
            rd_q     <= '0;
            m2r_q    <= 1'b0;
            mrd_q    <= 1'b0;
        end else begin
            valid_q  <= valid_f_mem;
            opcode_q <= opcode_f_mem;
            alu_q    <= alu_result_f_mem;
            mem_q    <= mem_data_f_mem;
            rd_q     <= rd_add_f_mem;
            m2r_q    <= mem_to_reg_f_mem;
            mrd_q    <= mem_read_f_mem;
        end
    end

    assign is_halt = valid_q && (opcode_q == OP_HALT);

    // State register; reset wins even over a HALT captured on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        w_2_id          = 1'b0;
        halted          = 1'b0;
        addr_2_id       = rd_q;
        write_data_2_id = mrd_q ? mem_q : alu_q;
        case (state_q)
            ST_RUN: begin
                // r0 writes are dropped here rather than relying on decode.
                w_2_id = valid_q && m2r_q && (rd_q != '0) && (opcode_q != OP_HALT);
                if (is_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

`ifdef WB_RETIRE_CNT_EN
    // Counts the instruction held in the stage register as it retires; the
    // HALT itself counts because it is still evaluated in ST_RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (valid_q && (state_q == ST_RUN) && (opcode_q != OP_NOP)
                     && (retire_cnt != 32'hFFFF_FFFF)) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule
